// File: rtl/pipe_pkg.sv
// Shared types and constants for the control-bundle pipeline stage.
//   pipe_state_t : occupancy FSM state (EMPTY / ONE / FULL)
//   OCC_*        : occupancy output encoding for each state
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  function automatic logic [1:0] occ_of(pipe_state_t s);
    case (s)
      PS_ONE:  return OCC_ONE;
      PS_FULL: return OCC_FULL;
      default: return OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : clock
//   reset : synchronous active-high clear
//   inc   : count one cycle when high
//   count : current value, sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset)                    cnt_q <= '0;
    else if (inc && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipe_ctrl_stage.sv
// Control-bundle pipeline register with valid/ready handshake and a
// two-entry skid buffer (main = head, skid = overflow entry).
//   clk, reset        : clock, synchronous active-high reset
//   flush             : drop all held entries at the next edge
//   stall             : block acceptance; held entries still drain
//   in_valid/in_data  : upstream bundle, in_ready back to upstream
//   out_valid/out_data: head entry (all-zero when not valid), out_ready in
//   occupancy         : held entries 0..2
//   bp_cycles         : saturating count of out_valid & !out_ready cycles
// in_ready depends only on state and stall, so there is no combinational
// path from out_ready back to in_ready.
module pipe_ctrl_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bp_cycles
);

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept, pop;

  assign in_ready  = (state_q != PS_FULL) && !stall;
  assign out_valid = (state_q != PS_EMPTY);
  assign out_data  = main_q;  // kept zero while EMPTY
  assign occupancy = occ_of(state_q);

  assign accept = in_valid && in_ready && !flush;
  assign pop    = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = PS_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (accept) begin
            state_d = PS_ONE;
            main_d  = in_data;
          end
        end
        PS_ONE: begin
          if (accept && pop) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = PS_FULL;
            skid_d  = in_data;
          end else if (pop) begin
            state_d = PS_EMPTY;
            main_d  = '0;
          end
        end
        PS_FULL: begin
          // in_ready is low here, so only a pop can move us
          if (pop) begin
            state_d = PS_ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = PS_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PS_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // flush deliberately does not clear the counter
  sat_counter #(.CNT_W(CNT_W)) u_bp_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid && !out_ready),
    .count (bp_cycles)
  );

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
module tb_pipe_ctrl_stage;

  localparam int DW = 2;
  localparam int CW = 3;

  logic          clk = 0;
  logic          reset, flush, stall, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] bp_cycles;

  int total = 0;
  int bad   = 0;

  pipe_ctrl_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .bp_cycles(bp_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two entries plus a saturating count.
  logic [DW-1:0] mq[$];
  int            mbp = 0;
  bit            started = 0;

  always @(posedge clk) begin
    bit rdy, acc, pp;
    rdy = (mq.size() < 2) && !stall;
    acc = in_valid && rdy && !flush;
    pp  = (mq.size() > 0) && out_ready;
    if (reset) begin
      mq.delete();
      mbp = 0;
    end else begin
      if (mq.size() > 0 && !out_ready && mbp < (1 << CW) - 1) mbp++;
      if (flush) mq.delete();
      else begin
        if (pp)  void'(mq.pop_front());
        if (acc) mq.push_back(in_data);
      end
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("in_ready",  int'(in_ready),  int'((mq.size() < 2) && !stall));
      check("out_valid", int'(out_valid), int'(mq.size() > 0));
      check("out_data",  int'(out_data),  (mq.size() > 0) ? int'(mq[0]) : 0);
      check("occupancy", int'(occupancy), mq.size());
      check("bp_cycles", int'(bp_cycles), mbp);
    end
  end

  task automatic step(input logic rs, input logic fl, input logic st,
                      input logic iv, input logic [DW-1:0] d, input logic ordy);
    reset = rs; flush = fl; stall = st; in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(1, 0, 0, 0, 2'b00, 0);
    step(1, 0, 0, 0, 2'b00, 0);
    // reset values
    check("rst_valid", int'(out_valid), 0);
    check("rst_occ",   int'(occupancy), 0);
    check("rst_bp",    int'(bp_cycles), 0);
    check("rst_data",  int'(out_data),  0);

    // streaming with out_ready high
    step(0, 0, 0, 1, 2'b01, 1);
    check("s1_data", int'(out_data), 1); check("s1_occ", int'(occupancy), 1);
    step(0, 0, 0, 1, 2'b10, 1);
    check("s2_data", int'(out_data), 2); check("s2_occ", int'(occupancy), 1);
    step(0, 0, 0, 1, 2'b11, 1);
    check("s3_data", int'(out_data), 3); check("s3_bp", int'(bp_cycles), 0);
    step(0, 0, 0, 0, 2'b00, 1);
    check("s4_occ", int'(occupancy), 0);

    // back-pressure fills skid
    step(0, 0, 0, 1, 2'b01, 0);
    check("bp1_occ", int'(occupancy), 1);
    step(0, 0, 0, 1, 2'b10, 0);
    check("bp2_occ", int'(occupancy), 2); check("bp2_rdy", int'(in_ready), 0);
    check("bp2_data", int'(out_data), 1);
    step(0, 0, 0, 0, 2'b00, 1);
    check("bp3_data", int'(out_data), 2);
    step(0, 0, 0, 0, 2'b00, 1);
    check("bp4_valid", int'(out_valid), 0);

    // flush while FULL with a competing input
    step(0, 0, 0, 1, 2'b01, 0);
    step(0, 0, 0, 1, 2'b10, 0);
    step(0, 1, 0, 1, 2'b11, 0);
    check("fl_valid", int'(out_valid), 0); check("fl_data", int'(out_data), 0);
    check("fl_occ", int'(occupancy), 0);
    step(0, 0, 0, 0, 2'b00, 1);
    check("fl_none", int'(out_valid), 0);

    // stall in ONE: head drains, input held off
    step(0, 0, 0, 1, 2'b01, 0);
    step(0, 0, 1, 1, 2'b10, 1);
    check("st_occ", int'(occupancy), 0); check("st_rdy", int'(in_ready), 0);
    step(0, 0, 1, 1, 2'b10, 1);
    check("st_occ2", int'(occupancy), 0);
    step(0, 0, 0, 1, 2'b10, 1);
    check("st_data", int'(out_data), 2);
    step(0, 0, 0, 0, 2'b00, 1);

    // counter saturation, survives flush, cleared by reset
    step(0, 0, 0, 1, 2'b11, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 2'b00, 0);
    check("sat_bp", int'(bp_cycles), 7);
    step(0, 1, 0, 0, 2'b00, 0);
    check("sat_flush", int'(bp_cycles), 7);
    step(1, 0, 0, 0, 2'b00, 0);
    check("sat_rst", int'(bp_cycles), 0);

    // reset while FULL
    step(0, 0, 0, 1, 2'b01, 0);
    step(0, 0, 0, 1, 2'b10, 0);
    step(1, 0, 0, 0, 2'b00, 0);
    check("rf_valid", int'(out_valid), 0); check("rf_occ", int'(occupancy), 0);
    check("rf_bp", int'(bp_cycles), 0);
    step(0, 0, 0, 0, 2'b00, 1);
    check("rf_none", int'(out_valid), 0);

    // random traffic against the model
    for (int i = 0; i < 500; i++)
      step(($urandom % 60) == 0, ($urandom % 30) == 0, ($urandom % 5) == 0,
           ($urandom % 4) != 0, 2'($urandom), ($urandom % 3) != 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_stage.md
# pipe_ctrl_stage

Parametrised control-bundle pipeline register with a valid/ready handshake and a two-entry skid buffer. It generalises the fixed two-bit EX/MEM control register to any bundle width. Upstream back-pressure, downstream stall and flush are decoupled without a combinational ready path from output to input. It sits between any two pipeline stages that carry control bits (EX/MEM, MEM/WB), and it guarantees that downstream logic sees an all-zero bundle (no memory op, no writeback) whenever no valid entry is present.

## Interface
Parameters:
- DATA_W, 2, width of the control bundle (e.g. {mem_read, mem_write}).
- CNT_W, 16, width of the saturating back-pressure cycle counter.

Ports:
- clk  input  1  clock. One clock domain; all state updates on posedge clk.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard all held entries; synchronous, takes effect at the next posedge.
- stall  input  1  hazard-unit stall; blocks acceptance only.
- in_valid  input  1  upstream bundle valid.
- in_data  input  DATA_W  upstream bundle.
- in_ready  output  1  stage can accept this cycle.
- out_valid  output  1  head entry valid.
- out_data  output  DATA_W  head entry. All-zero when out_valid=0.
- out_ready  input  1  downstream consumes the head this cycle.
- occupancy  output  2  held entries, 0..2.
- bp_cycles  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Storage: main register (head) and skid register. FSM states: EMPTY, ONE, FULL.
- accept = in_valid & in_ready & !flush. pop = out_valid & out_ready.
- in_ready = (state != FULL) & !stall. This depends only on state and stall, never on out_ready.
- out_valid = (state != EMPTY). out_data = main. main is all-zero in EMPTY.
- occupancy: EMPTY=0, ONE=1, FULL=2.
- State transitions:
  - EMPTY:
    - accept → ONE, main←in_data.
  - ONE:
    - accept & pop → ONE, main←in_data.
    - accept & !pop → FULL, skid←in_data.
    - !accept & pop → EMPTY, main←0.
    - otherwise hold.
  - FULL:
    - pop → ONE, main←skid, skid←0.
    - otherwise hold. in_ready=0, so accept is impossible.
- stall=1: no new entries are accepted. Held entries still drain via out_ready. stall does not clear anything.
- flush=1: next state EMPTY; main and skid ←0. Any simultaneous in_valid is dropped. A simultaneous pop is irrelevant.
- reset: same as flush, and additionally bp_cycles←0. reset has priority over flush.
- bp_cycles: increments when out_valid & !out_ready and the count is below 2^CNT_W−1. It holds at the maximum value. flush does not clear it.
- Ordering: entries leave in acceptance order. No entry is duplicated or lost except on flush or reset.
- Invariant: skid ≠ 0 only in FULL. main ≠ 0 only when not EMPTY.

## Timing
- Reset values: out_valid=0, out_data=0, occupancy=0, bp_cycles=0, in_ready=!stall.
- Latency: an entry accepted at edge N is on out_data/out_valid after edge N, i.e. in cycle N+1.
- Throughput: one entry per cycle when out_ready=1 continuously.
- Back-pressure: when out_ready drops, one further entry is absorbed into skid. in_ready falls in the cycle after the transition to FULL.
- flush/reset mid-operation: in the cycle after the edge, out_valid=0, out_data=0, occupancy=0, in_ready=!stall.
- Simultaneous accept & pop in ONE: occupancy stays 1 and the new data appears next cycle.

## Structure
- Shared package pipe_pkg: typedef enum logic [1:0] pipe_state_t {PS_EMPTY, PS_ONE, PS_FULL}. Also holds the occupancy encoding constants.
- One natural sub-module, sat_counter #(CNT_W), which implements bp_cycles. It has inputs clk, reset, inc and output count.
- The EX/MEM instance uses DATA_W=2 with bundle {mem_read, mem_write}.

## Test plan
- Reset, then stream 2'b01, 2'b10, 2'b11 with out_ready=1 → outputs appear one cycle later, in order, occupancy=1 throughout, bp_cycles=0.
- Hold out_ready=0, send 2'b01 then 2'b10 → occupancy 1 then 2, in_ready=0. Then raise out_ready → outputs are 2'b01 then 2'b10, and nothing is lost.
- In FULL, assert flush with in_valid=1, in_data=2'b11 → next cycle out_valid=0, out_data=2'b00, occupancy=0, and 2'b11 never appears.
- Assert stall=1 in ONE with out_ready=1 and in_valid=1 → in_ready=0, the head drains, state goes to EMPTY, and the input is not taken until stall drops.
- With CNT_W=3, hold out_valid=1 and out_ready=0 for 10 cycles → bp_cycles saturates at 7. A flush leaves it at 7; a reset clears it to 0.
- Assert reset in FULL while flush=0 → all outputs reach reset values the next cycle, and the skid contents are not emitted.
